// File: rtl/dadda_mul_arbiter_pkg.sv
// dadda_arb_pkg: shared widths, pipeline stage records and the round-robin
// pick function used by the dadda_mul_arbiter slice.
//   MUL_W / PROD_W : operand and product width of the dadda_6 core
//   s0_t           : operand stage record {id, a, b}
//   s1_t           : result stage record {id, product}
//   rr_pick        : first set bit of valid at or after ptr, wrapping mod n
package dadda_arb_pkg;

  localparam int unsigned MUL_W    = 6;
  localparam int unsigned PROD_W   = 12;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [MUL_W-1:0]    a;
    logic [MUL_W-1:0]    b;
  } s0_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } s1_t;

  // Returns ptr itself when nothing is valid; callers gate on |valid.
  function automatic logic [ID_MAX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [ID_MAX_W-1:0] ptr,
    input int unsigned         n
  );
    logic [ID_MAX_W-1:0] win;
    logic                found;
    int unsigned         j;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      j = (32'(ptr) + k) % n;
      if (!found && valid[j[ID_MAX_W-1:0]]) begin
        win   = j[ID_MAX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dadda_mul_arbiter_if.sv
// Interfaces for the dadda_mul_arbiter slice.
//   dadda_arb_if  : requester/response bus.
//     master = clients side (drive req_valid/req_a/req_b/rsp_ready)
//     slave  = arbiter side (drive req_ready/rsp_valid/rsp_id/rsp_product/busy)
//   if_multiplier : operand/product link to the dadda_6 core.
//     mul_side  = multiplier (consumes a/b, produces product/overflow)
//     core_side = user of the multiplier
interface dadda_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 6
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [2*WIDTH-1:0]            rsp_product;
  logic                          busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

interface if_multiplier #(
  parameter int unsigned W = 6
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           overflow;

  modport mul_side  (input  a, b, output product, overflow);
  modport core_side (output a, b, input  product, overflow);
endinterface

// File: rtl/dadda_6.sv
// dadda_6: combinational 6x6 unsigned multiplier.
// Partial-product rows are accumulated; synthesis maps the row sum onto a
// carry-save compression tree with a final carry-propagate adder.
//   mul.a, mul.b    : operands
//   mul.product     : full 12-bit product
//   mul.overflow    : product does not fit in 6 bits
module dadda_6
  import dadda_arb_pkg::*;
(
  if_multiplier.mul_side mul
);

  logic [PROD_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < MUL_W; i++) begin
      if (mul.b[i]) acc = acc + (PROD_W'(mul.a) << i);
    end
    mul.product  = acc;
    mul.overflow = |acc[PROD_W-1:MUL_W];
  end

endmodule

// File: rtl/dadda_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   valid  : request vector
//   ptr    : highest-priority index this cycle
//   enable : grant may be issued
//   grant  : one-hot grant, zero when disabled or nothing valid
//   index  : winning index (meaningful only when grant != 0)
module rr_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [MAX_REQ-1:0]  valid_ext;
  logic [ID_MAX_W-1:0] ptr_ext;

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
    ptr_ext          = '0;
    ptr_ext[IW-1:0]  = ptr;
    index            = IW'(rr_pick(valid_ext, ptr_ext, N));
    grant            = '0;
    if (enable && (|valid)) grant[index] = 1'b1;
  end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: shares one dadda_6 multiplier between NUM_REQ
// requesters. Round-robin grant into S0 {id,a,b}; the product is registered
// into S1 {id,product}, which drives the response channel directly.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : req_valid/req_ready/req_a/req_b per requester,
//                     rsp_valid/rsp_ready/rsp_id/rsp_product, busy
// Optional (DADDA_ARB_PERF_EN):
//   grant_cnt       : per-requester saturating transfer counters
//   stall_cnt       : saturating count of cycles with rsp_valid & !rsp_ready
module dadda_mul_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dadda_arb_if.slave               bus
`ifdef DADDA_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  if (WIDTH != MUL_W) begin : g_width_check
    $error("dadda_mul_arbiter: WIDTH must equal the dadda_6 operand width");
  end

  s0_t               s0_q;
  s1_t               s1_q;
  logic              s0_valid;
  logic              s1_valid;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic              s0_adv;
  logic              s1_adv;
  logic              arb_en;
  logic              xfer;

  if_multiplier #(.W(MUL_W)) mul_if ();

  dadda_6 u_mul (
    .mul (mul_if.mul_side)
  );

  assign mul_if.a = s0_q.a;
  assign mul_if.b = s0_q.b;

  // rst_n gates the arbiter so req_ready drops the moment reset asserts.
  always_comb begin
    s1_adv   = !s1_valid || bus.rsp_ready;
    s0_adv   = !s0_valid || s1_adv;
    arb_en   = s0_adv && rst_n;
    xfer     = |grant;
    next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid  (bus.req_valid),
    .ptr    (rr_ptr),
    .enable (arb_en),
    .grant  (grant),
    .index  (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q     <= '0;
      s1_q     <= '0;
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (xfer) begin
        s0_q.id  <= ID_MAX_W'(win_idx);
        s0_q.a   <= bus.req_a[win_idx];
        s0_q.b   <= bus.req_b[win_idx];
        s0_valid <= 1'b1;
        rr_ptr   <= next_ptr;
      end else if (s0_adv) begin
        s0_valid <= 1'b0;
      end
      if (s1_adv) begin
        s1_q.id      <= s0_q.id;
        s1_q.product <= mul_if.product;
        s1_valid     <= s0_valid;
      end
    end
  end

  always_comb begin
    bus.req_ready   = grant;
    bus.rsp_valid   = s1_valid;
    bus.rsp_id      = ID_W'(s1_q.id);
    bus.rsp_product = s1_q.product;
    bus.busy        = s0_valid || s1_valid;
  end

`ifdef DADDA_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && bus.req_valid[i] && (grant_cnt[i] != 16'hFFFF))
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      if (s1_valid && !bus.rsp_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
Shares one dadda_6 multiplier instance (reached through if_multiplier) between NUM_REQ requesters. A round-robin arbiter feeds a 2-stage pipeline: operand register, combinational Dadda tree, result register. Each product is returned on one response channel, tagged with the requester id. Sits between the multiplier clients and the approximate/exact Dadda datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 6, operand width; must match the instantiated Dadda multiplier
ID_W, $clog2(NUM_REQ), requester id width (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ x WIDTH  multiplicand per requester
req_b  in  NUM_REQ x WIDTH  multiplier per requester
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accept
rsp_id  out  ID_W  requester index that owns rsp_product
rsp_product  out  2*WIDTH  unsigned product a*b
busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (rst_n low, asynchronous): s0_valid=0, s1_valid=0, rr_ptr=0. req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0. Reset mid-operation discards all in-flight data with no response.
- Stages:
  - S0 holds {id,a,b}; dadda_6 multiplies its a and b combinationally.
  - S1 holds {id,product}. rsp_* is driven directly from S1.
- Stall rules:
  - s1_advance = !s1_valid | rsp_ready.
  - s0_advance = !s0_valid | s1_advance.
  - S1 loads from S0 when s1_advance. s1_valid takes the value of s0_valid.
- Arbitration:
  - Runs only when s0_advance.
  - The winner is the first requester with req_valid high, searching from rr_ptr upward (mod NUM_REQ).
  - req_ready[winner]=1; all other ready bits are 0. req_ready is 0 for every requester when !s0_advance.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high. On a transfer, S0 loads {i, req_a[i], req_b[i]} and rr_ptr becomes (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds. If S0 advances without a new grant, s0_valid goes to 0.
- req_ready is combinational from req_valid, rr_ptr and the stall state. Requesters must not make req_valid depend on req_ready.
- Latency: a transfer at edge N gives rsp_valid high after edge N+1. Throughput is one product per cycle when rsp_ready is held high.
- Backpressure:
  - rsp_valid high with rsp_ready low: rsp_id and rsp_product hold stable and S1 holds.
  - If S0 is also valid, S0 holds and no grant is issued.
  - No data is ever dropped or duplicated.
- A simultaneous response pop and new grant in the same cycle is legal and required for full throughput.
- Arithmetic: product is unsigned and exactly 2*WIDTH bits wide. The high bit comes from the multiplier output; it is not zero-padded.
- busy = s0_valid | s1_valid.
- Requesters keep their original order in the response stream. Only the interleaving between requesters depends on arbitration.

Optional Feature:
- DADDA_ARB_PERF_EN defined:
  - Adds grant_cnt output, NUM_REQ x 16: one saturating grant counter per requester, incremented on each transfer.
  - Adds stall_cnt output, 16: a saturating counter of cycles with rsp_valid & !rsp_ready.
  - All counters reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist. The core behaviour is identical in both cases.

Decomposition:
- Package dadda_arb_pkg holds:
  - localparams MUL_W=6 and PROD_W=12;
  - typedef s0_t {id, a, b};
  - typedef s1_t {id, product};
  - function rr_pick(valid, ptr) returning the winner index.
- One sub-module, rr_arbiter (parameter N): inputs valid, ptr, enable; outputs one-hot grant and index.
- The dadda_6 instance connects through if_multiplier.mul_side. Its overflow output is ignored.

Test Plan:
1. Reset release, all req_valid=0 → req_ready=0, rsp_valid=0, busy=0 for 10 cycles.
2. Requester 2 sends a=63, b=63, rsp_ready=1 → rsp_valid high 2 edges after the transfer, rsp_id=2, rsp_product=12'hF81 (3969).
3. All 4 requesters valid continuously, rsp_ready=1 → grants cycle 0,1,2,3,0,… with one response per cycle.
   - Products: 5*7=35, 6*9=54, 0*63=0, 1*1=1.
4. rsp_ready=0 for 5 cycles with 2 items queued → rsp_valid and data held, req_ready=0 for all, busy=1.
   - On release, both items appear in consecutive cycles in grant order.
5. Assert rst_n low while S0 and S1 are valid → all outputs 0 immediately, without waiting for a clock edge. After release, no stale response appears.
6. Exhaustive: all 4096 (a,b) pairs from random requesters with random rsp_ready → every product equals a*b and every id matches.
